// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared encodings for the multi-cycle MIPS controller: opcode and
//            funct values, FSM state encoding, instruction classes and the
//            select codes driven onto the NPC / ALU / write-back muxes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    // Funct codes (IR[5:0]) for op 0
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    // NPC select
    localparam logic [1:0] c_NPC_SEQ  = 2'b00;
    localparam logic [1:0] c_NPC_JMP  = 2'b01;
    localparam logic [1:0] c_NPC_BEQ  = 2'b10;
    localparam logic [1:0] c_NPC_JR   = 2'b11;

    // ALU operation
    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_OR   = 3'b010;
    localparam logic [2:0] c_ALU_LUI  = 3'b011;

    // Register-file write data select
    localparam logic [1:0] c_WD_ALU   = 2'b00;
    localparam logic [1:0] c_WD_DM    = 2'b01;
    localparam logic [1:0] c_WD_PC4   = 2'b10;

    // Register-file destination select
    localparam logic [1:0] c_GPR_RD   = 2'b00;
    localparam logic [1:0] c_GPR_RT   = 2'b01;
    localparam logic [1:0] c_GPR_RA   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXE     = 4'd2,
        S_MEM_ADR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_WB      = 4'd6,
        S_WB_MEM  = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CLS_RTYPE = 4'd0,
        CLS_ORI   = 4'd1,
        CLS_LUI   = 4'd2,
        CLS_LW    = 4'd3,
        CLS_SW    = 4'd4,
        CLS_BEQ   = 4'd5,
        CLS_J     = 4'd6,
        CLS_JAL   = 4'd7,
        CLS_JR    = 4'd8,
        CLS_ILL   = 4'd9
    } cls_t;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_decode
// Purpose  : Combinational instruction classifier, op/funct -> cls_t.
//            Op 0 is only legal for addu/subu (CLS_RTYPE) and jr (CLS_JR).
// Ports    : op    in  6  IR[31:26]
//            funct in  6  IR[5:0]
//            cls   out    instruction class (CLS_ILL when unsupported)
// Revision : 1.0 - initial release
// ============================================================================
module mc_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls
);

    always_comb begin
        cls = CLS_ILL;
        case (op)
            c_OP_RTYPE: begin
                if (funct == c_FN_ADDU || funct == c_FN_SUBU) begin
                    cls = CLS_RTYPE;
                end else if (funct == c_FN_JR) begin
                    cls = CLS_JR;
                end
            end
            c_OP_ORI: cls = CLS_ORI;
            c_OP_LUI: cls = CLS_LUI;
            c_OP_LW:  cls = CLS_LW;
            c_OP_SW:  cls = CLS_SW;
            c_OP_BEQ: cls = CLS_BEQ;
            c_OP_J:   cls = CLS_J;
            c_OP_JAL: cls = CLS_JAL;
            default:  cls = CLS_ILL;
        endcase
    end

endmodule : mc_decode
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle MIPS control FSM. Sequences PC/NPC, IR, register
//            file, ALU and data memory; waits on imem/dmem ready with a
//            watchdog; flags illegal instructions and stuck memory (sticky).
// Ports    : clk, rst (async, active-high)
//            op, funct, zero, imem_ready, dmem_ready        - inputs
//            NPCOp, PCWr, IRWr, RFWr, DMWr, DMRd, EXTOp,
//            ALUOp, ALUSrcB, WDSel, GPRSel                   - datapath control
//            illegal, timeout                                - sticky status
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic [1:0] NPCOp,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic       DMRd,
    output logic       EXTOp,
    output logic [2:0] ALUOp,
    output logic       ALUSrcB,
    output logic [1:0] WDSel,
    output logic [1:0] GPRSel,
    output logic       illegal,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    cls_t             w_cls;
    logic [CNT_W-1:0] r_wdog;
    logic             r_illegal;
    logic             r_timeout;
    logic             w_wait_state;
    logic             w_ready;
    logic             w_expired;
    logic             w_pcwr, w_irwr, w_rfwr, w_dmwr, w_dmrd;

    mc_decode u_decode (
        .op    (op),
        .funct (funct),
        .cls   (w_cls)
    );

    // Watchdog: the counter holds the number of wait cycles already spent in
    // the current wait state. The cycle on which it equals MEM_TIMEOUT with
    // ready still low is the expiry cycle; ready on that cycle still wins.
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                          (r_state == S_MEM_WR);
    assign w_ready      = (r_state == S_FETCH) ? imem_ready : dmem_ready;
    assign w_expired    = w_wait_state && !w_ready && (r_wdog == c_TIMEOUT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   if (imem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_cls)
                    CLS_RTYPE, CLS_ORI, CLS_LUI: w_next = S_EXE;
                    CLS_LW, CLS_SW:              w_next = S_MEM_ADR;
                    CLS_BEQ:                     w_next = S_BRANCH;
                    CLS_J, CLS_JAL, CLS_JR:      w_next = S_JUMP;
                    default:                     w_next = S_FETCH;
                endcase
            end
            S_EXE:     w_next = S_WB;
            S_MEM_ADR: w_next = (w_cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (dmem_ready) w_next = S_WB_MEM;
            S_MEM_WR:  if (dmem_ready) w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
        if (w_expired) begin
            w_next = S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_wdog    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            // Any transition (or expiry) leaves the wait, so the count restarts
            // from zero on entry to the next wait state.
            if (w_wait_state && !w_ready && !w_expired) begin
                r_wdog <= r_wdog + c_ONE;
            end else begin
                r_wdog <= '0;
            end
            if (r_state == S_DECODE && w_cls == CLS_ILL) begin
                r_illegal <= 1'b1;
            end
            if (w_expired) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        NPCOp   = c_NPC_SEQ;
        w_pcwr  = 1'b0;
        w_irwr  = 1'b0;
        w_rfwr  = 1'b0;
        w_dmwr  = 1'b0;
        w_dmrd  = 1'b0;
        EXTOp   = 1'b0;
        ALUOp   = c_ALU_ADD;
        ALUSrcB = 1'b0;
        WDSel   = c_WD_ALU;
        GPRSel  = c_GPR_RD;
        case (r_state)
            S_FETCH: begin
                w_irwr = imem_ready;
                w_pcwr = imem_ready;
            end
            S_EXE, S_WB: begin
                // ALU controls held through WB so the result is stable while written.
                case (w_cls)
                    CLS_ORI: begin
                        ALUOp   = c_ALU_OR;
                        ALUSrcB = 1'b1;
                    end
                    CLS_LUI: begin
                        ALUOp   = c_ALU_LUI;
                        ALUSrcB = 1'b1;
                    end
                    default: ALUOp = (funct == c_FN_SUBU) ? c_ALU_SUB : c_ALU_ADD;
                endcase
                if (r_state == S_WB) begin
                    w_rfwr = 1'b1;
                    GPRSel = (w_cls == CLS_RTYPE) ? c_GPR_RD : c_GPR_RT;
                end
            end
            S_MEM_ADR: begin
                ALUOp   = c_ALU_ADD;
                ALUSrcB = 1'b1;
                EXTOp   = 1'b1;
            end
            S_MEM_RD: w_dmrd = 1'b1;
            S_MEM_WR: w_dmwr = 1'b1;
            S_WB_MEM: begin
                w_rfwr = 1'b1;
                WDSel  = c_WD_DM;
                GPRSel = c_GPR_RT;
            end
            S_BRANCH: begin
                ALUOp  = c_ALU_SUB;
                NPCOp  = c_NPC_BEQ;
                w_pcwr = zero;
            end
            S_JUMP: begin
                w_pcwr = 1'b1;
                if (w_cls == CLS_JR) begin
                    NPCOp = c_NPC_JR;
                end else begin
                    NPCOp = c_NPC_JMP;
                end
                if (w_cls == CLS_JAL) begin
                    w_rfwr = 1'b1;
                    WDSel  = c_WD_PC4;
                    GPRSel = c_GPR_RA;
                end
            end
            default: ;
        endcase
    end

    // Reset and watchdog expiry both suppress every write strobe immediately.
    assign PCWr    = w_pcwr & ~rst & ~w_expired;
    assign IRWr    = w_irwr & ~rst & ~w_expired;
    assign RFWr    = w_rfwr & ~rst & ~w_expired;
    assign DMWr    = w_dmwr & ~rst & ~w_expired;
    assign DMRd    = w_dmrd & ~rst & ~w_expired;
    assign illegal = r_illegal;
    assign timeout = r_timeout;

endmodule : mc_ctrl
`default_nettype wire
